// File: rtl/cpu6_pipelinereg_hs_pkg.sv
// Shared constants for the CPU6 handshaked pipeline register: the MEM/WB
// payload layout (widths and field offsets) and the occupancy encodings.
package cpu6_pipelinereg_hs_pkg;

    localparam int CPU6_XLEN        = 32;
    localparam int CPU6_RFIDX_WIDTH = 5;

    // MEM/WB payload = {regwrite, writereg, rd, empty_pipeline_req}
    localparam int CPU6_MEMWB_W            = CPU6_XLEN + CPU6_RFIDX_WIDTH + 2;
    localparam int CPU6_MEMWB_EPR_LSB      = 0;
    localparam int CPU6_MEMWB_RD_LSB       = CPU6_MEMWB_EPR_LSB + 1;
    localparam int CPU6_MEMWB_WRITEREG_LSB = CPU6_MEMWB_RD_LSB + CPU6_XLEN;
    localparam int CPU6_MEMWB_REGWRITE_LSB = CPU6_MEMWB_WRITEREG_LSB + CPU6_RFIDX_WIDTH;

    // Occupancy of the stage (number of held beats)
    localparam logic [1:0] CNT_EMPTY = 2'd0;
    localparam logic [1:0] CNT_ONE   = 2'd1;
    localparam logic [1:0] CNT_TWO   = 2'd2;

    typedef struct packed {
        logic                        regwrite;
        logic [CPU6_RFIDX_WIDTH-1:0] writereg;
        logic [CPU6_XLEN-1:0]        rd;
        logic                        empty_pipeline_req;
    } memwb_t;

    // Packs the MEM/WB fields so producers and consumers agree on the layout
    function automatic logic [CPU6_MEMWB_W-1:0] memwb_pack(
        input logic                        regwrite,
        input logic [CPU6_RFIDX_WIDTH-1:0] writereg,
        input logic [CPU6_XLEN-1:0]        rd,
        input logic                        epr
    );
        memwb_t p;
        p.regwrite           = regwrite;
        p.writereg           = writereg;
        p.rd                 = rd;
        p.empty_pipeline_req = epr;
        return p;
    endfunction

endpackage

// File: rtl/cpu6_pipelinereg_hs_dffre.sv
// Basic flops for the CPU6 pipeline: cpu6_dffr is a plain register with
// synchronous active-high reset to zero; cpu6_dffre adds a load enable on top.
module cpu6_dffr #(
    parameter int W = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);
    logic [W-1:0] q_q;

    // Register with synchronous clear
    always_ff @(posedge clk_i) begin
        if (rst_i) q_q <= '0;
        else       q_q <= d_i;
    end

    assign q_o = q_q;
endmodule

module cpu6_dffre #(
    parameter int W = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);
    logic [W-1:0] q_d;

    // Recirculate the held value when not enabled
    assign q_d = en_i ? d_i : q_o;

    cpu6_dffr #(.W(W)) u_dffr (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (q_d),
        .q_o   (q_o)
    );
endmodule

// File: rtl/cpu6_pipelinereg_hs.sv
// CPU6 handshaked pipeline register. Carries a packed payload between two
// stages with valid/ready flow control, an optional 2-entry skid buffer and a
// synchronous flush. The main register always holds the oldest beat.
module cpu6_pipelinereg_hs
    import cpu6_pipelinereg_hs_pkg::*;
#(
    parameter int DW         = CPU6_MEMWB_W,
    parameter int SKID       = 1,
    parameter int FLUSH_ZERO = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [1:0]    count
);
    logic [1:0]    count_q, count_d;
    logic [DW-1:0] main_q, main_d;
    logic [DW-1:0] skid_q, skid_d;
    logic          main_en, skid_en;
    logic          in_fire, out_fire;

    // A beat shown during a flush cycle is killed and never transfers
    assign out_valid = (count_q != CNT_EMPTY) & ~flush;
    assign out_fire  = out_valid & out_ready;
    assign in_fire   = in_valid & in_ready & ~flush;
    assign out_data  = main_q;
    assign count     = count_q;

    generate
        if (SKID != 0) begin : g_rdy_reg
            logic full_q, full_d;

            // Registered "full" flag keeps in_ready free of any out_ready path
            assign full_d = (count_d == CNT_TWO);

            cpu6_dffre #(.W(1)) u_full (
                .clk_i (clk),
                .rst_i (reset),
                .en_i  (1'b1),
                .d_i   (full_d),
                .q_o   (full_q)
            );

            assign in_ready = ~full_q & ~reset;

            cpu6_dffre #(.W(DW)) u_skid (
                .clk_i (clk),
                .rst_i (reset),
                .en_i  (skid_en),
                .d_i   (skid_d),
                .q_o   (skid_q)
            );
        end else begin : g_rdy_comb
            logic unused_skid;

            // Single entry: accept when empty or when the held beat leaves now
            assign in_ready    = ((count_q == CNT_EMPTY) | out_ready) & ~reset;
            assign skid_q      = '0;
            assign unused_skid = ^{skid_d, skid_en};
        end
    endgenerate

    // Occupancy transitions and storage loads; flush overrides all fire events
    always_comb begin
        count_d = count_q;
        main_d  = main_q;
        main_en = 1'b0;
        skid_d  = skid_q;
        skid_en = 1'b0;
        if (flush) begin
            count_d = CNT_EMPTY;
            if (FLUSH_ZERO != 0) begin
                main_d  = '0;
                main_en = 1'b1;
                skid_d  = '0;
                skid_en = 1'b1;
            end
        end else begin
            case (count_q)
                CNT_EMPTY: begin
                    if (in_fire) begin
                        count_d = CNT_ONE;
                        main_d  = in_data;
                        main_en = 1'b1;
                    end
                end
                CNT_ONE: begin
                    if (in_fire && out_fire) begin
                        main_d  = in_data;
                        main_en = 1'b1;
                    end else if (in_fire && (SKID != 0)) begin
                        count_d = CNT_TWO;
                        skid_d  = in_data;
                        skid_en = 1'b1;
                    end else if (out_fire) begin
                        count_d = CNT_EMPTY;
                    end
                end
                CNT_TWO: begin
                    if (out_fire) begin
                        count_d = CNT_ONE;
                        main_d  = skid_q;
                        main_en = 1'b1;
                    end
                end
                default: count_d = CNT_EMPTY;
            endcase
        end
    end

    cpu6_dffre #(.W(DW)) u_main (
        .clk_i (clk),
        .rst_i (reset),
        .en_i  (main_en),
        .d_i   (main_d),
        .q_o   (main_q)
    );

    cpu6_dffre #(.W(2)) u_count (
        .clk_i (clk),
        .rst_i (reset),
        .en_i  (1'b1),
        .d_i   (count_d),
        .q_o   (count_q)
    );

endmodule
